// File: rtl/jelly_graycode_counter.sv
// Up/down counter that keeps a binary count and its Gray image in lockstep, with wrap flags.
// Latency: one cycle. An operation sampled on an enabled edge is visible right after that edge.
// Backpressure: none. cke=0 freezes every register, including carry and borrow.
module jelly_graycode_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             cke,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_binary,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] graycode,
    output logic             carry,
    output logic             borrow
);

    logic [WIDTH-1:0] next_binary;
    logic             next_carry;
    logic             next_borrow;

    // Priority is clear > load > inc/dec; inc and dec together cancel out.
    always_comb begin
        next_binary = binary;
        next_carry  = 1'b0;
        next_borrow = 1'b0;
        if (clear) begin
            next_binary = INIT;
        end else if (load) begin
            next_binary = load_binary;
        end else if (inc && !dec) begin
            next_binary = binary + 1'b1;
            next_carry  = &binary;
        end else if (dec && !inc) begin
            next_binary = binary - 1'b1;
            next_borrow = ~|binary;
        end
    end

    // Gray is derived from the next count so it is never a cycle behind binary.
    always_ff @(posedge clk) begin
        if (reset) begin
            binary   <= INIT;
            graycode <= INIT ^ (INIT >> 1);
            carry    <= 1'b0;
            borrow   <= 1'b0;
        end else if (cke) begin
            binary   <= next_binary;
            graycode <= next_binary ^ (next_binary >> 1);
            carry    <= next_carry;
            borrow   <= next_borrow;
        end
    end

endmodule

// File: tb/tb_jelly_graycode_counter.sv
// Directed bench for the Gray counter: WIDTH=4 with INIT=0, plus an INIT=6 instance for reset values.
module tb_jelly_graycode_counter;

    logic       clk = 1'b0;
    logic       reset, cke, clear, load, inc, dec;
    logic [3:0] load_binary;
    logic [3:0] binary, graycode, binary6, graycode6;
    logic       carry, borrow, carry6, borrow6;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] prev_gray;
    logic [3:0] exp_bin;

    always #5 clk = ~clk;

    jelly_graycode_counter #(.WIDTH(4), .INIT(4'd0)) u_dut (
        .reset(reset), .clk(clk), .cke(cke), .clear(clear), .load(load),
        .load_binary(load_binary), .inc(inc), .dec(dec),
        .binary(binary), .graycode(graycode), .carry(carry), .borrow(borrow)
    );

    jelly_graycode_counter #(.WIDTH(4), .INIT(4'd6)) u_dut6 (
        .reset(reset), .clk(clk), .cke(cke), .clear(clear), .load(load),
        .load_binary(load_binary), .inc(inc), .dec(dec),
        .binary(binary6), .graycode(graycode6), .carry(carry6), .borrow(borrow6)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; clear = 1'b0; load = 1'b0;
        inc = 1'b0; dec = 1'b0; load_binary = 4'd0;
        step();
        chk("rst_bin", binary, 4'd0);
        chk("rst_gray", graycode, 4'd0);
        chk("rst_carry", carry, 1'b0);
        chk("rst_borrow", borrow, 1'b0);
        chk("rst6_bin", binary6, 4'd6);
        chk("rst6_gray", graycode6, 4'b0101);

        // Full up-count through the wrap.
        reset = 1'b0; inc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_gray = graycode;
            step();
            exp_bin = 4'(i);
            chk("up_bin", binary, exp_bin);
            chk("up_gray", graycode, exp_bin ^ (exp_bin >> 1));
            chk("up_carry", carry, (i == 16));
            chk("up_gray_1bit", $countones(graycode ^ prev_gray), 1);
            if (i == 4) chk("up_gray4", graycode, 4'b0110);
        end

        // Down-wrap from 0.
        inc = 1'b0; dec = 1'b1;
        prev_gray = graycode;
        step();
        chk("dn_bin15", binary, 4'd15);
        chk("dn_gray15", graycode, 4'b1000);
        chk("dn_borrow1", borrow, 1'b1);
        chk("dn_gray_1bit", $countones(graycode ^ prev_gray), 1);
        step();
        chk("dn_bin14", binary, 4'd14);
        chk("dn_gray14", graycode, 4'b1001);
        chk("dn_borrow0", borrow, 1'b0);

        // Load beats inc; clear beats load.
        dec = 1'b0; inc = 1'b1; load = 1'b1; load_binary = 4'd5;
        step();
        chk("ld_bin", binary, 4'd5);
        chk("ld_gray", graycode, 4'b0111);
        chk("ld_carry", carry, 1'b0);
        clear = 1'b1;
        step();
        chk("clr_bin", binary, 4'd0);
        chk("clr_gray", graycode, 4'd0);

        // inc and dec together cancel; cke=0 freezes.
        clear = 1'b0; inc = 1'b0; load_binary = 4'd3;
        step();
        load = 1'b0; inc = 1'b1; dec = 1'b1;
        step();
        chk("both_bin", binary, 4'd3);
        chk("both_gray", graycode, 4'b0010);
        chk("both_carry", carry, 1'b0);
        chk("both_borrow", borrow, 1'b0);
        dec = 1'b0; cke = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cke0_bin", binary, 4'd3);
        end

        // Carry pulse is held while cke=0.
        cke = 1'b1; inc = 1'b0; load = 1'b1; load_binary = 4'd15;
        step();
        load = 1'b0; inc = 1'b1;
        step();
        chk("wrap_carry", carry, 1'b1);
        chk("wrap_bin", binary, 4'd0);
        cke = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_carry", carry, 1'b1);
            chk("hold_bin", binary, 4'd0);
        end
        cke = 1'b1; inc = 1'b0;
        step();
        chk("idle_carry", carry, 1'b0);
        chk("idle_bin", binary, 4'd0);

        // Reset mid-count overrides inc.
        load = 1'b1; load_binary = 4'd9;
        step();
        chk("pre_rst_bin", binary, 4'd9);
        load = 1'b0; inc = 1'b1; reset = 1'b1;
        step();
        chk("mid_rst_bin", binary, 4'd0);
        chk("mid_rst_gray", graycode, 4'd0);
        chk("mid_rst_carry", carry, 1'b0);
        chk("mid_rst_borrow", borrow, 1'b0);
        chk("mid_rst6_bin", binary6, 4'd6);
        chk("mid_rst6_gray", graycode6, 4'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
